// File: rtl/cal_flags_pkg.sv
// Shared constants, types and the condition-code evaluator for the
// registered ALU flag block.
package cal_flags_pkg;

    localparam logic [2:0] OP_ADD       = 3'b110;
    localparam logic [2:0] OP_SUB       = 3'b111;
    localparam logic [1:0] OP_ARITH_PFX = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } valid_state_e;

    // Pure decode of a condition code against a flag set; validity gating
    // is applied by the caller.
    function automatic logic cond_eval(
        input logic [3:0] cond,
        input logic       c,
        input logic       n,
        input logic       z,
        input logic       v
    );
        logic hit;
        hit = 1'b0;
        case (cond)
            COND_EQ: hit = z;
            COND_NE: hit = ~z;
            COND_CS: hit = c;
            COND_CC: hit = ~c;
            COND_MI: hit = n;
            COND_PL: hit = ~n;
            COND_VS: hit = v;
            COND_VC: hit = ~v;
            COND_HI: hit = c & ~z;
            COND_LS: hit = ~c | z;
            COND_GE: hit = (n == v);
            COND_LT: hit = (n != v);
            COND_GT: hit = ~z & (n == v);
            COND_LE: hit = z | (n != v);
            COND_AL: hit = 1'b1;
            COND_NV: hit = 1'b0;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/cal_flags_if.sv
// Bus between the ALU datapath / branch logic and the flag register.
// flag_we and sticky_clr are single-cycle strobes sampled on the rising
// clock edge; there is no back-pressure, every asserted strobe is taken.
interface cal_flags_if
    import cal_flags_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic [2:0]       op;
    logic [WIDTH-1:0] result;
    logic             co_add;
    logic             co_prev_add;
    logic             flag_we;
    logic             sticky_clr;
    logic [3:0]       cond;

    logic             c;
    logic             n;
    logic             z;
    logic             v;
    logic             flags_valid;
    logic             cond_true;
    logic             sticky_c;
    logic             sticky_v;
    logic [CNT_W-1:0] ovf_cnt;
    logic             ovf_cnt_sat;
    valid_state_e     dbg_state;

    modport master (
        output op, result, co_add, co_prev_add, flag_we, sticky_clr, cond,
        input  c, n, z, v, flags_valid, cond_true, sticky_c, sticky_v,
               ovf_cnt, ovf_cnt_sat, dbg_state
    );

    modport slave (
        input  op, result, co_add, co_prev_add, flag_we, sticky_clr, cond,
        output c, n, z, v, flags_valid, cond_true, sticky_c, sticky_v,
               ovf_cnt, ovf_cnt_sat, dbg_state
    );

endinterface

// File: rtl/cal_flags_nx.sv
// Combinational next-flag calculator: C/N/Z/V from an ALU result and the
// adder's top two carries.
module cal_flags_nx
    import cal_flags_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] result,
    input  logic             co_add,
    input  logic             co_prev_add,
    output logic             c_nx,
    output logic             n_nx,
    output logic             z_nx,
    output logic             v_nx
);

    logic arith;
    logic unused_op0;

    // Only the opcode class matters; op[0] selects ADD vs SUB in the ALU.
    assign unused_op0 = op[0];

    always_comb begin
        arith = (op[2:1] == OP_ARITH_PFX);
        c_nx  = arith ? co_add : 1'b0;
        n_nx  = result[WIDTH-1];
        z_nx  = ~|result;
        v_nx  = arith ? (co_add ^ co_prev_add) : 1'b0;
    end

endmodule

// File: rtl/cal_flags_reg.sv
// Registered ALU status flags with sticky C/V, saturating overflow counter
// and a branch-condition evaluator on the stored flags.
module cal_flags_reg
    import cal_flags_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    cal_flags_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic c_nx, n_nx, z_nx, v_nx;

    valid_state_e     state_q, state_d;
    logic             c_q, c_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             sticky_c_q, sticky_c_d;
    logic             sticky_v_q, sticky_v_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic             c_event;
    logic             v_event;
    logic             flags_valid;

    cal_flags_nx #(
        .WIDTH(WIDTH)
    ) u_nx (
        .op         (bus.op),
        .result     (bus.result),
        .co_add     (bus.co_add),
        .co_prev_add(bus.co_prev_add),
        .c_nx       (c_nx),
        .n_nx       (n_nx),
        .z_nx       (z_nx),
        .v_nx       (v_nx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            c_q        <= 1'b0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            v_q        <= 1'b0;
            sticky_c_q <= 1'b0;
            sticky_v_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            n_q        <= n_d;
            z_q        <= z_d;
            v_q        <= v_d;
            sticky_c_q <= sticky_c_d;
            sticky_v_q <= sticky_v_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Valid FSM: leaves EMPTY on the first capture and never returns
    // until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (bus.flag_we) state_d = ST_VALID;
            ST_VALID: state_d = ST_VALID;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        c_d = c_q;
        n_d = n_q;
        z_d = z_q;
        v_d = v_q;
        if (bus.flag_we) begin
            c_d = c_nx;
            n_d = n_nx;
            z_d = z_nx;
            v_d = v_nx;
        end
    end

    // A set event in the same cycle as a clear wins, so no event is lost.
    always_comb begin
        c_event    = bus.flag_we & c_nx;
        v_event    = bus.flag_we & v_nx;
        sticky_c_d = (sticky_c_q & ~bus.sticky_clr) | c_event;
        sticky_v_d = (sticky_v_q & ~bus.sticky_clr) | v_event;

        ovf_cnt_d = ovf_cnt_q;
        if (v_event) begin
            if (bus.sticky_clr) begin
                ovf_cnt_d = CNT_W'(1);
            end else if (ovf_cnt_q != CNT_MAX) begin
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
        end else if (bus.sticky_clr) begin
            ovf_cnt_d = '0;
        end
    end

    assign flags_valid     = (state_q == ST_VALID);

    assign bus.c           = c_q;
    assign bus.n           = n_q;
    assign bus.z           = z_q;
    assign bus.v           = v_q;
    assign bus.flags_valid = flags_valid;
    assign bus.cond_true   = flags_valid & cond_eval(bus.cond, c_q, n_q, z_q, v_q);
    assign bus.sticky_c    = sticky_c_q;
    assign bus.sticky_v    = sticky_v_q;
    assign bus.ovf_cnt     = ovf_cnt_q;
    assign bus.ovf_cnt_sat = (ovf_cnt_q == CNT_MAX);
    assign bus.dbg_state   = state_q;

endmodule
